tag_free_list: RTL

- Issues 3-bit transaction tags from a pool of 8. Downstream 3-bit equality comparators match completion or broadcast tags against these issued tags.
- When a tag retires, this block takes it back and returns it to the pool.
- Tag storage is a circular FIFO of free tags plus a busy bitmap, so illegal frees can be detected.
- Sits between the request issue stage and the completion/broadcast bus.

---
 rtl/tag_free_list.sv | 88 ++++++++
 1 files changed

// File: rtl/tag_free_list.sv
// Transaction tag pool: circular FIFO of free tags plus a busy bitmap.
// Zero-latency grant from the FIFO head; returned tags are pushed at the tail.
module tag_free_list #(
  parameter int TAG_W    = 3,
  parameter int NUM_TAGS = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  output logic             free_err,
  output logic [CNT_W-1:0] free_cnt,
  output logic             empty,
  output logic             all_free
);

  logic [TAG_W-1:0]    fifo_q [NUM_TAGS];
  logic [TAG_W-1:0]    head_q, head_d;
  logic [TAG_W-1:0]    tail_q, tail_d;
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [NUM_TAGS-1:0] set_dec, clr_dec, wr_dec, busy_hit;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                empty_q, all_free_q, err_q;
  logic                free_ok, free_bad;

  assign alloc_tag = fifo_q[head_q];
  assign alloc_gnt = alloc_req & ~empty_q;

  // Busy is looked up before this cycle's grant takes effect.
  always_comb begin
    set_dec  = '0;
    clr_dec  = '0;
    wr_dec   = '0;
    busy_hit = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      busy_hit[i] = busy_q[i] & (free_tag == TAG_W'(i));
      set_dec[i]  = alloc_gnt & (alloc_tag == TAG_W'(i));
    end
    free_ok  = free_valid & (|busy_hit);
    free_bad = free_valid & ~(|busy_hit);
    for (int i = 0; i < NUM_TAGS; i++) begin
      clr_dec[i] = free_ok & (free_tag == TAG_W'(i));
      wr_dec[i]  = free_ok & (tail_q == TAG_W'(i));
    end
  end

  always_comb begin
    head_d = alloc_gnt ? head_q + TAG_W'(1) : head_q;
    tail_d = free_ok ? tail_q + TAG_W'(1) : tail_q;
    busy_d = (busy_q | set_dec) & ~clr_dec;
    cnt_d  = cnt_q;
    if (free_ok && !alloc_gnt) cnt_d = cnt_q + CNT_W'(1);
    if (!free_ok && alloc_gnt) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAGS; i++) fifo_q[i] <= TAG_W'(i);
      head_q     <= '0;
      tail_q     <= '0;
      busy_q     <= '0;
      cnt_q      <= CNT_W'(NUM_TAGS);
      empty_q    <= 1'b0;
      all_free_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++)
        if (wr_dec[i]) fifo_q[i] <= free_tag;
      head_q     <= head_d;
      tail_q     <= tail_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      empty_q    <= (cnt_d == '0);
      all_free_q <= (cnt_d == CNT_W'(NUM_TAGS));
      err_q      <= free_bad;
    end
  end

  assign free_err = err_q;
  assign free_cnt = cnt_q;
  assign empty    = empty_q;
  assign all_free = all_free_q;

endmodule
